// File: rtl/booth_seq_mult.sv
// Iterative signed radix-4 Booth multiplier, one recoded digit per clock.
// Optional early termination when BOOTH_SEQ_MULT_EARLY_TERM_EN is defined.

module booth_recoder (
  input  logic [2:0] triple,
  output logic       negate,
  output logic       zero,
  output logic       shift
);
  assign negate = triple[2];
  assign zero   = (triple == 3'b000) || (triple == 3'b111);
  assign shift  = (triple == 3'b011) || (triple == 3'b100);
endmodule

module booth_seq_mult #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH:0]       mplier_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   product_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic                 dig_neg, dig_zero, dig_shift;
  logic [2*WIDTH-1:0]   pp_mag, pp, acc_next;
  logic                 last_digit;

  booth_recoder u_recoder (
    .triple (mplier_reg[2:0]),
    .negate (dig_neg),
    .zero   (dig_zero),
    .shift  (dig_shift)
  );

  always_comb begin
    pp_mag = '0;
    if (!dig_zero)
      pp_mag = dig_shift ? (mcand_reg << 1) : mcand_reg;
    pp       = dig_neg ? (~pp_mag + 1'b1) : pp_mag;
    acc_next = acc_reg + pp;
  end

`ifdef BOOTH_SEQ_MULT_EARLY_TERM_EN
  // Bits above the current triple all equal the sign: every later digit is zero.
  logic [WIDTH-2:0] rest_bits;
  logic             rest_trivial;
  assign rest_bits    = mplier_reg[WIDTH:2];
  assign rest_trivial = (~|rest_bits) || (&rest_bits);
  assign last_digit   = rest_trivial || (cnt_reg == CNT_W'(WIDTH/2 - 1));
`else
  assign last_digit   = (cnt_reg == CNT_W'(WIDTH/2 - 1));
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid_i) state_next = BUSY;
      BUSY:    if (last_digit) state_next = DONE;
      DONE:    if (out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_reg == IDLE);
    busy_o      = (state_reg == BUSY);
    out_valid_o = (state_reg == DONE);
    product_o   = product_reg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid_i) begin
          mcand_reg  <= {{WIDTH{multiplicand_i[WIDTH-1]}}, multiplicand_i};
          mplier_reg <= {multiplier_i, 1'b0};
          acc_reg    <= '0;
          cnt_reg    <= '0;
        end
        BUSY: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 2;
          mplier_reg <= {{2{mplier_reg[WIDTH]}}, mplier_reg[WIDTH:2]};
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_digit)
            product_reg <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult at WIDTH=8.
// Early-termination vectors run only when BOOTH_SEQ_MULT_EARLY_TERM_EN is defined.

module tb_booth_seq_mult;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] product;
  logic           busy;

  int checks = 0;
  int errors = 0;

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .multiplicand_i (a),
    .multiplier_i   (b),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .product_o      (product),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected latency: full WIDTH/2, or the first digit after which B is pure sign.
  function automatic int ref_lat(input logic [W-1:0] bv);
`ifdef BOOTH_SEQ_MULT_EARLY_TERM_EN
    logic signed [W-1:0] s;
    for (int k = 1; k <= W/2; k++) begin
      s = $signed(bv) >>> (2*k - 1);
      if (s == 0 || s == -1) return k;
    end
`endif
    return W/2;
  endfunction

  // Issue one op, wait for the result, check latency/product, optionally drain.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp, input int lat, input bit drain);
    int edges;
    @(negedge clk);
    check({tag, " ready_before"}, 32'(in_ready), 32'd1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0;
    edges = 0;
    while (!out_valid && edges < 50) begin
      check({tag, " ready_low_busy"}, 32'(in_ready), 32'd0);
      check({tag, " busy_high"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " latency"}, 32'(edges), 32'(lat));
    check({tag, " product"}, 32'(product), 32'(exp));
    check({tag, " ready_low_done"}, 32'(in_ready), 32'd0);
    $display("op %s: A=%0h B=%0h product=%0h latency=%0d", tag, av, bv, product, edges);
    if (drain) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " idle_ready"}, 32'(in_ready), 32'd1);
      check({tag, " idle_valid"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [2*W-1:0] held;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("3x5",       8'd3,   8'd5,   16'h000F, ref_lat(8'd5),   1'b1);
    run_op("-7x6",      8'hF9,  8'd6,   16'hFFD6, ref_lat(8'd6),   1'b1);
    run_op("-128x-128", 8'h80,  8'h80,  16'h4000, ref_lat(8'h80),  1'b1);
    run_op("127x-128",  8'h7F,  8'h80,  16'hC080, ref_lat(8'h80),  1'b1);
    run_op("55x0",      8'h55,  8'h00,  16'h0000, ref_lat(8'h00),  1'b1);
    run_op("0xAB",      8'h00,  8'hAB,  16'h0000, ref_lat(8'hAB),  1'b1);

    // Backpressure: result must hold and in_valid pulses must be ignored.
    run_op("bp 3x7",    8'd3,   8'd7,   16'h0015, ref_lat(8'd7),   1'b0);
    held = product;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      check("bp valid", 32'(out_valid), 32'd1);
      check("bp product", 32'(product), 32'(held));
      check("bp ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; a = '0; b = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release ready", 32'(in_ready), 32'd1);
    check("bp release valid", 32'(out_valid), 32'd0);

    // Asynchronous abort two edges into BUSY.
    @(negedge clk);
    a = 8'd5; b = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort product", 32'(product), 32'd0);
    $display("abort: reset applied mid-operation");
    @(negedge clk);
    rst = 1'b0;
    run_op("2x3",       8'd2,   8'd3,   16'h0006, ref_lat(8'd3),   1'b1);

`ifdef BOOTH_SEQ_MULT_EARLY_TERM_EN
    run_op("et 3x1",    8'd3,   8'd1,   16'h0003, 1, 1'b1);
    run_op("et 3x-1",   8'd3,   8'hFF,  16'hFFFD, 1, 1'b1);
    run_op("et 3x40",   8'd3,   8'h40,  16'h00C0, 4, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
